aes_cipher_writeback: RTL
=========================

# aes_cipher_writeback

Ciphertext write-back initiator for the hardware AES path. Accepts one 128-bit ciphertext block plus a destination byte address from the AES core over a valid/ready handshake. Serialises the block into four 32-bit word writes on the data-cache side-write port (`wen_aes_d` / `cipher_addr` / `cipher_text`), so the RISC-V core can later load the result from data memory. It sits between the AES core output and the data cache, and drives that port exclusively.

## Interface
- `ADD_WIDTH`, 18: data-memory byte-address width. Address arithmetic wraps modulo 2^ADD_WIDTH.
- `CNT_WIDTH`, 16: width of the completed-block counter.

- `clk`  in  1  clock; all state on its rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `ct_valid`  in  1  ciphertext block and base address are valid.
- `ct_ready`  out  1  block accepted at a rising edge where `ct_valid && ct_ready`.
- `ct_data`  in  128  ciphertext; bits [127:96] are the first word.
- `ct_base`  in  32  destination byte address; bits [1:0] ignored.
- `wen_aes_d`  out  1  side-port write strobe, one word per cycle.
- `cipher_addr`  out  32  word-aligned byte address of the current write.
- `cipher_text`  out  32  write data of the current word.
- `done`  out  1  one-cycle pulse: a full block has been written.
- `busy`  out  1  high while a block is being written.
- `blk_count`  out  CNT_WIDTH  number of completed blocks since reset.

## Operation
- **States**
  - IDLE: waiting for a block.
  - WRITE: 2-bit beat counter 0..3.
- **Accept**
  - `ct_ready` = (state==IDLE) || (state==WRITE && beat==3).
  - On handshake, latch `ct_data` into a 128-bit holding register, latch `ct_base` with [1:0] forced to 0, set beat=0, and enter WRITE.
- **WRITE beat i (0..3)**
  - `wen_aes_d`=1.
  - `cipher_addr` = {zeros, (base + 4*i) mod 2^ADD_WIDTH}; bits [31:ADD_WIDTH] = 0.
  - `cipher_text` = word i of the holding register (i=0 → [127:96], i=3 → [31:0]).
- **Leaving beat 3**
  - With a handshake in the same cycle: go to beat 0 of the new block, with no idle gap.
  - Otherwise: go to IDLE.
- **In IDLE**
  - `wen_aes_d`=0.
  - `cipher_addr`, `cipher_text` hold 0.
- **Completion**
  - `done` is registered high for exactly one cycle after each beat-3 cycle.
  - `blk_count` increments on that same edge and wraps from 2^CNT_WIDTH−1 to 0.
- `busy` = (state==WRITE).
- `ct_data` and `ct_base` changes while not handshaking have no effect.
- **Reset, including mid-block**
  - The state machine returns to IDLE, and any remaining beats are abandoned.
  - Words already written stay in memory.
  - `done` is not pulsed.

## Timing
- Reset values:
  - `ct_ready`=1
  - `wen_aes_d`=0
  - `cipher_addr`=0
  - `cipher_text`=0
  - `done`=0
  - `busy`=0
  - `blk_count`=0
- All outputs are registered except `ct_ready` and `busy`, which decode the state registers only (no combinational path from inputs).
- Handshake at edge k gives beats in cycles k+1..k+4 and `done` in cycle k+5.
- Each memory word commits at the edge ending its beat cycle.
- Sustained throughput: one block per 4 cycles, with `wen_aes_d` continuously high.

## Configuration
- `AES_WB_BYTESWAP_EN`
  - Defined: each 32-bit word is byte-reversed before driving `cipher_text` (AES byte 0 lands at the lowest byte address, little-endian). For example, word 0x00112233 is written as 0x33221100.
  - Undefined: words are written unmodified.
- Addresses, beat order and timing are identical in both builds.

## Test plan
- **Single block**
  - Stimulus: reset, then present `ct_data`=0x00112233_44556677_8899AABB_CCDDEEFF with `ct_base`=0x00000100.
  - Response: writes (0x100,0x00112233), (0x104,0x44556677), (0x108,0x8899AABB), (0x10C,0xCCDDEEFF) in cycles k+1..k+4; `done` high only in cycle k+5; `blk_count`=1.
- **Back-to-back**
  - Stimulus: hold `ct_valid` high for two blocks.
  - Response: second block is accepted in its beat-3 cycle; `wen_aes_d` stays high for 8 consecutive cycles; two `done` pulses 4 cycles apart.
- **Wrap and alignment**
  - Stimulus: `ct_base`=0x0003FFFB with ADD_WIDTH=18.
  - Response: addresses 0x3FFF8, 0x3FFFC, 0x00000, 0x00004.
- **Reset mid-block**
  - Stimulus: assert `reset` asynchronously during beat 1.
  - Response: `wen_aes_d` drops immediately; outputs take reset values; no `done`; `blk_count`=0.
- **Ignored input during WRITE**
  - Stimulus: change `ct_data` and `ct_base` during beats 0..2 with `ct_valid`=0.
  - Response: written words still match the latched block.
- **Byte-swap build**
  - Stimulus: single-block test with `AES_WB_BYTESWAP_EN` defined.
  - Response: first write data is 0x33221100 at address 0x100.

Source files
------------

// File: rtl/aes_cipher_writeback.sv
// AES ciphertext write-back initiator.
// Accepts one 128-bit block and a base address, then writes it out as four
// consecutive 32-bit words on the data-cache side-write port.
// Optional build macro: AES_WB_BYTESWAP_EN byte-reverses each written word.
module aes_cipher_writeback #(
   parameter int unsigned ADD_WIDTH = 18,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ct_valid,
   output logic                 ct_ready,
   input  logic [127:0]         ct_data,
   input  logic [31:0]          ct_base,
   output logic                 wen_aes_d,
   output logic [31:0]          cipher_addr,
   output logic [31:0]          cipher_text,
   output logic                 done,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] blk_count
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_WRITE = 1'b1;

   logic                 state_q, state_d;
   logic [1:0]           beat_q, beat_d;
   logic [127:0]         hold_q, hold_d;
   logic [ADD_WIDTH-1:0] base_q, base_d;
   logic                 wen_d;
   logic [31:0]          addr_d, text_d;
   logic                 done_d;
   logic [CNT_WIDTH-1:0] count_d;
   logic [ADD_WIDTH-1:0] addr_sum;
   logic                 handshake, last_beat;
   logic                 unused_base;

   // Address bits above the memory width and the byte offset are dropped
   assign unused_base = ^{ct_base[31:ADD_WIDTH], ct_base[1:0]};

   assign ct_ready  = (state_q == ST_IDLE) || (beat_q == 2'd3);
   assign busy      = (state_q == ST_WRITE);
   assign handshake = ct_valid && ct_ready;
   assign last_beat = (state_q == ST_WRITE) && (beat_q == 2'd3);

   // Word i of a block, most significant word first
   function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
      unique case (idx)
         2'd0:    word_sel = blk[127:96];
         2'd1:    word_sel = blk[95:64];
         2'd2:    word_sel = blk[63:32];
         default: word_sel = blk[31:0];
      endcase
   endfunction

   function automatic logic [31:0] wb_format(input logic [31:0] w);
`ifdef AES_WB_BYTESWAP_EN
      wb_format = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      wb_format = w;
`endif
   endfunction

   // Next state, and the registered write port contents for the coming cycle
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      hold_d  = hold_q;
      base_d  = base_q;
      if (handshake) begin
         state_d = ST_WRITE;
         beat_d  = 2'd0;
         hold_d  = ct_data;
         base_d  = {ct_base[ADD_WIDTH-1:2], 2'b00};
      end else if (state_q == ST_WRITE) begin
         if (beat_q == 2'd3) begin
            state_d = ST_IDLE;
            beat_d  = 2'd0;
         end else begin
            beat_d = beat_q + 2'd1;
         end
      end

      addr_sum = base_d + ADD_WIDTH'({beat_d, 2'b00});
      wen_d    = (state_d == ST_WRITE);
      addr_d   = wen_d ? 32'(addr_sum) : 32'd0;
      text_d   = wen_d ? wb_format(word_sel(hold_d, beat_d)) : 32'd0;
      done_d   = last_beat;
      count_d  = blk_count + CNT_WIDTH'(last_beat);
   end

   // State and registered outputs; reset abandons any block in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         beat_q      <= 2'd0;
         hold_q      <= '0;
         base_q      <= '0;
         wen_aes_d   <= 1'b0;
         cipher_addr <= 32'd0;
         cipher_text <= 32'd0;
         done        <= 1'b0;
         blk_count   <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         hold_q      <= hold_d;
         base_q      <= base_d;
         wen_aes_d   <= wen_d;
         cipher_addr <= addr_d;
         cipher_text <= text_d;
         done        <= done_d;
         blk_count   <= count_d;
      end
   end

endmodule
